mau_rmw_unit: RTL and testbench
===============================

# mau_rmw_unit

Parametrised memory access unit with atomic read-modify-write. Holds a DEPTH x WIDTH register-file memory and executes one request at a time: read, write, add, subtract, bitwise AND/OR/XOR and swap. Requests and responses each use a valid/ready handshake. Every response returns the pre-operation value (fetch-and-op) plus overflow and error flags. It sits between the core's load/store stage and local data memory, replacing the fixed-width unhandshaked access unit.

## Interface
- WIDTH, 32, data word width in bits (>= 2)
- DEPTH, 16, number of memory words (>= 2, need not be a power of two); ADDR_W = $clog2(DEPTH) is derived, not overridable
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  3  operation code
- req_addr  in  ADDR_W  word address
- req_wdata  in  WIDTH  operand
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_data  out  WIDTH  memory value before the operation
- resp_ovf  out  1  ADD carry-out or SUB borrow
- resp_err  out  1  address out of range

## Operation
- Opcodes:
  - 0 READ
  - 1 WRITE (mem = wdata)
  - 2 ADD (mem = mem + wdata)
  - 3 SUB (mem = mem - wdata)
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 SWAP (mem = wdata). SWAP and WRITE differ only in intent; both return the old value.
- Arithmetic is unsigned, at WIDTH bits. Default behaviour is modulo wrap.
- resp_ovf is 1 only for ADD with carry out of bit WIDTH-1, or SUB where mem < wdata. It is 0 for all other ops.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch op/addr/wdata and go to EXEC.
  - EXEC: read mem[addr] and compute the result. At the closing edge, write the result (READ writes nothing), register resp_data/resp_ovf/resp_err, set resp_valid and go to RESP.
  - RESP: hold all resp_* outputs stable until resp_ready.
    - resp_ready=1 and req_valid=1: accept the new request (req_ready=1) and go to EXEC.
    - resp_ready=1 and req_valid=0: go to IDLE.
- req_ready = (state==IDLE) || (state==RESP && resp_ready). It is combinational from state and resp_ready.
- Out-of-range access (addr >= DEPTH):
  - no memory write
  - resp_data=0, resp_ovf=0, resp_err=1
  - the handshake proceeds normally
- A request to the same address as the previous request sees the previous write, because memory is updated before the next EXEC.
- Illegal opcodes cannot occur, since all 8 codes are defined.

## Timing
- Reset values:
  - state=IDLE
  - req_ready=1
  - resp_valid=0
  - resp_data=0, resp_ovf=0, resp_err=0
  - every memory word cleared to 0
- Latency: request accepted at edge E0, memory written and resp_valid=1 after edge E1. The response is therefore visible in the cycle after EXEC.
- Throughput: one request per 2 cycles when resp_ready is held high.
- Backpressure: while resp_valid && !resp_ready, all resp_* outputs and memory are frozen and req_ready=0.
- Reset asserted during EXEC: the memory is cleared and the in-flight operation is discarded. No partial write or response survives.
- Reset asserted during RESP: the pending response is dropped and resp_valid falls immediately (asynchronous).

## Configuration
- MAU_SATURATE_EN defined:
  - ADD clamps to all-ones on carry.
  - SUB clamps to 0 on borrow.
  - resp_ovf still flags that the clamp occurred.
- MAU_SATURATE_EN undefined: modulo wrap as described above. resp_ovf keeps the same meaning.
- Only ADD/SUB results change between the two builds. Timing and handshake are identical.

## Structure
- mau_pkg:
  - opcode enum (MAU_READ..MAU_SWAP)
  - opcode width constant (3)
  - default WIDTH/DEPTH constants
- Sub-module mau_alu: purely combinational.
  - Inputs: op, old value, operand.
  - Outputs: new value, ovf, write-enable.
  - Contains the MAU_SATURATE_EN logic.
- mau_rmw_unit: top level containing the FSM, memory array, request latch and response registers.

## Test plan
- WIDTH=16, DEPTH=16:
  - WRITE addr 10 data 0xABCD -> resp_data=0x0000.
  - Then READ addr 10 -> resp_data=0xABCD, ovf=0, err=0.
- ADD addr 10 data 0x1234 -> resp_data=0xABCD. A following READ -> 0xBE01.
- WRITE 0xFFF0 to addr 3, then ADD 0x0020 -> resp_ovf=1. A following READ returns:
  - 0x0010 when MAU_SATURATE_EN is undefined
  - 0xFFFF when MAU_SATURATE_EN is defined
- WRITE 0x0005 to addr 4, then SUB 0x0007 -> resp_ovf=1. A following READ returns 0xFFFE (wrap build) or 0x0000 (saturate build).
- DEPTH=12: WRITE addr 13 data 0x5555 -> resp_err=1, resp_data=0. Then READ every address 0..11 -> all 0 (no aliasing write).
- Backpressure: hold resp_ready=0 for 3 cycles after an XOR response with req_valid high.
  - Required: resp_* stable, req_ready=0.
- Reset: drop rst_n low during EXEC of a WRITE 0x1111 to addr 2.
  - Required: outputs go to their reset values at once.
  - A READ of addr 2 after release returns 0.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared opcode and sizing definitions for the memory access unit.
package mau_pkg;

  localparam int unsigned OpWidth      = 3;
  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 16;

  typedef enum logic [OpWidth-1:0] {
    MAU_READ  = 3'd0,
    MAU_WRITE = 3'd1,
    MAU_ADD   = 3'd2,
    MAU_SUB   = 3'd3,
    MAU_AND   = 3'd4,
    MAU_OR    = 3'd5,
    MAU_XOR   = 3'd6,
    MAU_SWAP  = 3'd7
  } mau_op_e;

endpackage

// File: rtl/mau_alu.sv
// Combinational read-modify-write datapath for mau_rmw_unit.
// Define MAU_SATURATE_EN to clamp ADD/SUB instead of wrapping.
module mau_alu
  import mau_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  mau_op_e            op_i,
  input  logic [WIDTH-1:0]   old_val_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [WIDTH-1:0]   new_val_o,
  output logic               ovf_o,
  output logic               we_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign sum    = {1'b0, old_val_i} + {1'b0, operand_i};
  assign diff   = old_val_i - operand_i;
  assign borrow = old_val_i < operand_i;

  always_comb begin
    new_val_o = old_val_i;
    ovf_o     = 1'b0;
    we_o      = 1'b1;
    case (op_i)
      MAU_READ:            we_o = 1'b0;
      MAU_WRITE, MAU_SWAP: new_val_o = operand_i;
      MAU_ADD: begin
        ovf_o = sum[WIDTH];
`ifdef MAU_SATURATE_EN
        new_val_o = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        new_val_o = sum[WIDTH-1:0];
`endif
      end
      MAU_SUB: begin
        ovf_o = borrow;
`ifdef MAU_SATURATE_EN
        new_val_o = borrow ? '0 : diff;
`else
        new_val_o = diff;
`endif
      end
      MAU_AND:  new_val_o = old_val_i & operand_i;
      MAU_OR:   new_val_o = old_val_i | operand_i;
      MAU_XOR:  new_val_o = old_val_i ^ operand_i;
      default:  we_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mau_rmw_unit.sv
// Handshaked memory access unit with atomic fetch-and-op on a DEPTH x WIDTH register file.
// Optional build macro MAU_SATURATE_EN (see mau_alu) selects saturating ADD/SUB.
module mau_rmw_unit
  import mau_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OpWidth-1:0]       req_op,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_ovf,
  output logic                     resp_err
);

  localparam int unsigned       AddrW  = $clog2(DEPTH);
  localparam logic [AddrW:0]    DepthW = (AddrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  mau_op_e          op_q;
  logic [AddrW-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             in_range;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] new_val;
  logic             alu_ovf;
  logic             alu_we;

  // Non-power-of-two depths leave addresses that decode to no word.
  assign in_range  = {1'b0, addr_q} < DepthW;
  assign old_val   = in_range ? mem_q[addr_q] : '0;
  assign req_ready = (state_q == StIdle) || ((state_q == StResp) && resp_ready);

  mau_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_i      (op_q),
    .old_val_i (old_val),
    .operand_i (wdata_q),
    .new_val_o (new_val),
    .ovf_o     (alu_ovf),
    .we_o      (alu_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= MAU_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_ovf   <= 1'b0;
      resp_err   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= mau_op_e'(req_op);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (in_range && alu_we) begin
            mem_q[addr_q] <= new_val;
          end
          resp_data  <= old_val;
          resp_ovf   <= in_range && alu_ovf;
          resp_err   <= !in_range;
          resp_valid <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (req_valid) begin
              op_q    <= mau_op_e'(req_op);
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              state_q <= StExec;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mau_rmw_unit.sv
// Self-checking bench for mau_rmw_unit: directed table, corner sequences and random vs. a model.
module tb_mau_rmw_unit;
  import mau_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 12;
  localparam int unsigned AW = 4;
`ifdef MAU_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [W-1:0]  resp_data;
  logic          resp_ovf;
  logic          resp_err;

  int checks = 0;
  int passed = 0;
  logic [W-1:0] model_mem [D];

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  exp_data;
    logic          exp_ovf;
    logic          exp_err;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mau_rmw_unit #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_ovf   (resp_ovf),
    .resp_err   (resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                         input logic [W-1:0] ed, input logic eo, input logic ee);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.exp_data = ed; v.exp_ovf = eo; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(D); i++) model_mem[i] = '0;
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                          output logic [W-1:0] d, output logic o, output logic e);
    int unsigned a, b, r;
    bit inr;
    inr = int'(addr) < int'(D);
    a = inr ? int'(model_mem[addr]) : 0;
    b = wd;
    r = a;
    o = 1'b0;
    case (op)
      3'd1, 3'd7: r = b;
      3'd2: begin
        r = a + b;
        o = r > 32'hFFFF;
        if (o) r = Sat ? 32'hFFFF : r - 32'h10000;
      end
      3'd3: begin
        o = a < b;
        if (o) r = Sat ? 0 : a + 32'h10000 - b;
        else r = a - b;
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = a;
    endcase
    if (!inr) begin
      d = '0; o = 1'b0; e = 1'b1;
    end else begin
      d = a[W-1:0]; e = 1'b0;
      if (op != 3'd0) model_mem[addr] = r[W-1:0];
    end
  endtask

  // One full transaction; stall holds resp_ready low for that many cycles after the response.
  task automatic txn(input logic [2:0] op, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                     input int stall, output logic [W-1:0] d, output logic o, output logic e,
                     output int lat);
    int n;
    resp_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    repeat (stall) @(negedge clk);
    d = resp_data; o = resp_ovf; e = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_model(input logic [2:0] op, input logic [AW-1:0] addr,
                           input logic [W-1:0] wd, input int stall, input string name);
    logic [W-1:0] d, ed;
    logic o, e, eo, ee;
    int lat;
    model_op(op, addr, wd, ed, eo, ee);
    txn(op, addr, wd, stall, d, o, e, lat);
    chk({name, "_data"}, 32'(d), 32'(ed));
    chk({name, "_ovf"}, 32'(o), 32'(eo));
    chk({name, "_err"}, 32'(e), 32'(ee));
    chk({name, "_latency"}, lat, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d, ed;
    logic o, e, eo, ee;
    int lat, n;

    add_vec(MAU_WRITE, 4'd13, 16'h5555, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < int'(D); i++) add_vec(MAU_READ, AW'(i), 16'h0, 16'h0000, 1'b0, 1'b0);
    add_vec(MAU_WRITE, 4'd10, 16'hABCD, 16'h0000, 1'b0, 1'b0);
    add_vec(MAU_READ,  4'd10, 16'h0000, 16'hABCD, 1'b0, 1'b0);
    add_vec(MAU_ADD,   4'd10, 16'h1234, 16'hABCD, 1'b0, 1'b0);
    add_vec(MAU_READ,  4'd10, 16'h0000, 16'hBE01, 1'b0, 1'b0);
    add_vec(MAU_WRITE, 4'd3,  16'hFFF0, 16'h0000, 1'b0, 1'b0);
    add_vec(MAU_ADD,   4'd3,  16'h0020, 16'hFFF0, 1'b1, 1'b0);
    add_vec(MAU_READ,  4'd3,  16'h0000, Sat ? 16'hFFFF : 16'h0010, 1'b0, 1'b0);
    add_vec(MAU_WRITE, 4'd4,  16'h0005, 16'h0000, 1'b0, 1'b0);
    add_vec(MAU_SUB,   4'd4,  16'h0007, 16'h0005, 1'b1, 1'b0);
    add_vec(MAU_READ,  4'd4,  16'h0000, Sat ? 16'h0000 : 16'hFFFE, 1'b0, 1'b0);
    add_vec(MAU_SWAP,  4'd10, 16'h0F0F, 16'hBE01, 1'b0, 1'b0);
    add_vec(MAU_OR,    4'd10, 16'hF000, 16'h0F0F, 1'b0, 1'b0);
    add_vec(MAU_AND,   4'd10, 16'h0FF0, 16'hFF0F, 1'b0, 1'b0);
    add_vec(MAU_READ,  4'd10, 16'h0000, 16'h0F00, 1'b0, 1'b0);
    add_vec(MAU_ADD,   4'd15, 16'hFFFF, 16'h0000, 1'b0, 1'b1);

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", 32'(resp_data), 32'd0);
    chk("reset_resp_ovf", 32'(resp_ovf), 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    model_clear();

    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, i % 2, d, o, e, lat);
      model_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, ed, eo, ee);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), lat, 2);
    end

    // Backpressure on an XOR response with the next request already waiting.
    run_model(MAU_WRITE, 4'd5, 16'h00FF, 0, "bp_setup");
    model_op(MAU_XOR, 4'd5, 16'h0F0F, ed, eo, ee);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = MAU_XOR; req_addr = 4'd5; req_wdata = 16'h0F0F;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_data", k), 32'(resp_data), 32'(ed));
      chk($sformatf("bp%0d_ovf", k), 32'(resp_ovf), 32'd0);
      chk($sformatf("bp%0d_err", k), 32'(resp_err), 32'd0);
      chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
      if (k < 3) @(negedge clk);
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    model_op(MAU_XOR, 4'd5, 16'h0F0F, ed, eo, ee);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    chk("b2b_latency", lat, 2);
    chk("b2b_data", 32'(resp_data), 32'(ed));
    @(posedge clk);
    #1;

    // Reset during EXEC discards the in-flight write and clears memory.
    run_model(MAU_WRITE, 4'd2, 16'h7777, 0, "rst_setup_w");
    run_model(MAU_READ, 4'd2, 16'h0000, 0, "rst_setup_r");
    @(negedge clk);
    req_valid = 1'b1; req_op = MAU_WRITE; req_addr = 4'd2; req_wdata = 16'h1111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_exec_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_exec_req_ready", 32'(req_ready), 32'd1);
    chk("rst_exec_resp_data", 32'(resp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    run_model(MAU_READ, 4'd2, 16'h0000, 0, "rst_exec_read2");
    run_model(MAU_READ, 4'd5, 16'h0000, 0, "rst_exec_read5");

    // Reset during RESP drops the pending response asynchronously.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = MAU_READ; req_addr = 4'd1; req_wdata = 16'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    chk("rst_resp_pending", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_resp_dropped", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    model_clear();

    for (int i = 0; i < 150; i++) begin
      logic [2:0]    rop;
      logic [AW-1:0] raddr;
      logic [W-1:0]  rwd;
      rop = 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(12, 15)) : AW'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rwd = 16'hFFFF - 16'($urandom_range(0, 15));
        1: rwd = 16'($urandom_range(0, 15));
        default: rwd = 16'($urandom);
      endcase
      run_model(rop, raddr, rwd, $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
